mac_seq_controller: RTL and testbench
=====================================

Name: mac_seq_controller

Overview:
Sequencer for a time-multiplexed neuron datapath: one shared multiply-accumulate unit serves N neurons, each summing N weighted activations per iteration. The controller steps row/column indices, clears the accumulator, writes back each neuron result, and commits the new activation vector. It checks the datapath convergence flag after each iteration and stops on convergence or when the iteration cap is reached. It sits beside the MAC datapath, replacing a flat one-shot multiply/add/writeback FSM.

Parameters:
N, 4, number of neurons; also inputs per neuron (N >= 2).
IDX_W, 2, width of row/column index, ceil(log2 N).
MAX_ITER, 16, iteration cap before forced stop.
ITER_W, 5, iteration counter width; must hold MAX_ITER.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  level request; the run begins after start falls.
isfinished  in  1  datapath convergence flag; sampled only in CHECK.
init_w  out  1  load weight memory/registers.
init_x  out  1  load initial activations.
clr_acc  out  1  clear MAC accumulator.
mac_en  out  1  accumulate weight[sel_row][sel_col] * act[sel_col].
sel_row  out  IDX_W  current neuron index.
sel_col  out  IDX_W  current input index.
wb_en  out  1  write accumulator result to next-activation slot wb_addr.
wb_addr  out  IDX_W  equals sel_row.
commit  out  1  copy next-activation vector to current vector.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse in DONE.
timeout  out  1  sticky; set when stopped by iteration cap; cleared on rst or on entry to INIT.

Behaviour:
- Moore FSM. States: IDLE, INIT, CLEAR, MAC, WB, COMMIT, CHECK, DONE. State register, row/col counters, iteration counter and timeout are clocked on posedge clk and reset on posedge rst.
- Reset: state IDLE, row=col=iter=0, timeout=0. All outputs are 0 during and after reset.
- rst asserted mid-run aborts immediately to IDLE. No done pulse is generated.
- IDLE: start=1 moves to INIT next cycle; otherwise stays in IDLE.
- INIT: init_w=init_x=1. Stays while start=1. start=0 moves to CLEAR with row=col=iter=0 and timeout cleared.
- CLEAR: clr_acc=1, col:=0. Next state is MAC.
- MAC: mac_en=1, sel_row=row, sel_col=col.
  - col<N-1: col increments and the FSM stays in MAC.
  - col=N-1: next state is WB. MAC lasts exactly N cycles.
- WB: wb_en=1, wb_addr=row.
  - row<N-1: row increments, next state is CLEAR.
  - row=N-1: row:=0, next state is COMMIT.
- COMMIT: commit=1, iter increments (saturating at MAX_ITER). Next state is CHECK.
- CHECK, in priority order:
  - isfinished=1: go to DONE with timeout=0.
  - else iter==MAX_ITER: go to DONE and set timeout=1.
  - else: go to CLEAR.
  - Convergence wins when convergence and the cap occur together.
- DONE: done=1 for exactly one cycle, then IDLE.
- Outside IDLE and INIT, start is ignored. A start held high through DONE re-enters INIT from IDLE on the following cycle.
- Iteration length: N*(N+2)+2 cycles. For N=4 this is 26. DONE is entered 26*k cycles after the first CLEAR cycle, where k is the number of iterations run.
- sel_row/sel_col hold their counter values in all states and read 0 in IDLE. All outputs are decoded only from state and counters, with no input-to-output combinational path.

Decomposition:
- Shared package mac_seq_pkg holds:
  - state encodings (3-bit localparams IDLE..DONE);
  - default N, IDX_W, MAX_ITER, ITER_W;
  - iteration-length constant N*(N+2)+2 for benches.
- One natural sub-module, idx_counter, instantiated twice (row, col) and once more with ITER_W width for iter. Ports: clk, rst, clr, en, q, at_last (q == LAST parameter).

Test Plan:
- Reset then idle: rst pulse, start=0 for 10 cycles -> all outputs 0, busy=0.
- Single iteration, N=4: start high 3 cycles then low, isfinished=1 at the first CHECK.
  - Required: init_w/init_x high 3 cycles; 4 blocks of clr_acc, 4 mac_en cycles (col 0..3), wb_en with wb_addr 0..3; one commit; done pulse 26 cycles after the first CLEAR; timeout=0.
- Convergence on third iteration: isfinished=1 only in the third CHECK -> exactly 3 commits, done at cycle 78 after the first CLEAR, timeout=0.
- Cap hit with MAX_ITER=16: isfinished held 0 -> 16 commits, done at cycle 416, timeout=1 until the next INIT, then 0.
- Simultaneous cap and convergence: isfinished=1 at the 16th CHECK -> done, timeout=0.
- Reset mid-run: rst asserted during MAC of row 2 -> same-cycle IDLE, all outputs 0, no done. A new start then runs a full iteration from row 0, col 0.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared encodings and default sizing for the time-multiplexed neuron MAC sequencer.
package mac_seq_pkg;

  localparam int unsigned N_DEF        = 4;
  localparam int unsigned IDX_W_DEF    = 2;
  localparam int unsigned MAX_ITER_DEF = 16;
  localparam int unsigned ITER_W_DEF   = 5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_CLEAR  = 3'd2;
  localparam logic [2:0] ST_MAC    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_COMMIT = 3'd5;
  localparam logic [2:0] ST_CHECK  = 3'd6;
  localparam logic [2:0] ST_DONE   = 3'd7;

  typedef enum logic [2:0] {
    StIdle   = ST_IDLE,
    StInit   = ST_INIT,
    StClear  = ST_CLEAR,
    StMac    = ST_MAC,
    StWb     = ST_WB,
    StCommit = ST_COMMIT,
    StCheck  = ST_CHECK,
    StDone   = ST_DONE
  } state_e;

  // Cycles per iteration: N rows of (CLEAR + N MAC + WB), then COMMIT and CHECK.
  function automatic int unsigned iter_len(input int unsigned n);
    return n * (n + 2) + 2;
  endfunction

  localparam int unsigned ITER_LEN_DEF = iter_len(N_DEF);

endpackage

// File: rtl/idx_counter.sv
// Up-counter with synchronous clear and a flag for reaching a fixed last value.
module idx_counter #(
  parameter int unsigned W    = 2,
  parameter int unsigned LAST = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         at_last
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q       = r_q;
  assign at_last = (r_q == W'(LAST));

endmodule

// File: rtl/mac_seq_controller.sv
// Moore sequencer driving a shared MAC across N neurons, iterating until the
// datapath converges or the iteration cap forces a stop.
module mac_seq_controller
  import mac_seq_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned IDX_W    = IDX_W_DEF,
  parameter int unsigned MAX_ITER = MAX_ITER_DEF,
  parameter int unsigned ITER_W   = ITER_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             isfinished,
  output logic             init_w,
  output logic             init_x,
  output logic             clr_acc,
  output logic             mac_en,
  output logic [IDX_W-1:0] sel_row,
  output logic [IDX_W-1:0] sel_col,
  output logic             wb_en,
  output logic [IDX_W-1:0] wb_addr,
  output logic             commit,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  state_e r_state, w_state_d;
  logic r_init, r_clr, r_mac, r_wb, r_commit, r_busy, r_done, r_timeout;

  logic [IDX_W-1:0]  w_row, w_col;
  logic [ITER_W-1:0] w_iter;
  logic w_row_last, w_col_last, w_iter_last;
  logic w_row_clr, w_row_en, w_col_clr, w_col_en, w_iter_clr, w_iter_en;

  // Counters are zeroed in INIT and DONE so the indices read 0 whenever idle.
  assign w_col_clr  = (r_state == StInit) || (r_state == StClear) || (r_state == StDone);
  assign w_col_en   = (r_state == StMac) && !w_col_last;
  assign w_row_clr  = (r_state == StInit) || (r_state == StDone) ||
                      ((r_state == StWb) && w_row_last);
  assign w_row_en   = (r_state == StWb) && !w_row_last;
  assign w_iter_clr = (r_state == StInit) || (r_state == StDone);
  assign w_iter_en  = (r_state == StCommit) && (w_iter < ITER_W'(MAX_ITER));

  idx_counter #(.W(IDX_W), .LAST(N - 1)) u_row (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_row_clr),
    .en      (w_row_en),
    .q       (w_row),
    .at_last (w_row_last)
  );

  idx_counter #(.W(IDX_W), .LAST(N - 1)) u_col (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_col_clr),
    .en      (w_col_en),
    .q       (w_col),
    .at_last (w_col_last)
  );

  idx_counter #(.W(ITER_W), .LAST(MAX_ITER)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_iter_clr),
    .en      (w_iter_en),
    .q       (w_iter),
    .at_last (w_iter_last)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   w_state_d = start ? StInit : StIdle;
      StInit:   w_state_d = start ? StInit : StClear;
      StClear:  w_state_d = StMac;
      StMac:    w_state_d = w_col_last ? StWb : StMac;
      StWb:     w_state_d = w_row_last ? StCommit : StClear;
      StCommit: w_state_d = StCheck;
      StCheck:  w_state_d = (isfinished || w_iter_last) ? StDone : StClear;
      StDone:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_init    <= 1'b0;
      r_clr     <= 1'b0;
      r_mac     <= 1'b0;
      r_wb      <= 1'b0;
      r_commit  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_init   <= (w_state_d == StInit);
      r_clr    <= (w_state_d == StClear);
      r_mac    <= (w_state_d == StMac);
      r_wb     <= (w_state_d == StWb);
      r_commit <= (w_state_d == StCommit);
      r_busy   <= (w_state_d != StIdle);
      r_done   <= (w_state_d == StDone);
      if ((r_state == StIdle) && start) begin
        r_timeout <= 1'b0;
      end else if (r_state == StCheck) begin
        r_timeout <= !isfinished && w_iter_last;
      end
    end
  end

  assign init_w  = r_init;
  assign init_x  = r_init;
  assign clr_acc = r_clr;
  assign mac_en  = r_mac;
  assign sel_row = w_row;
  assign sel_col = w_col;
  assign wb_en   = r_wb;
  assign wb_addr = w_row;
  assign commit  = r_commit;
  assign busy    = r_busy;
  assign done    = r_done;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_mac_seq_controller.sv
// Scoreboard bench: an independent event model per run is compared against
// the DUT's clr/mac/wb/commit/done activity, cycle-accurately from the first CLEAR.
module tb_mac_seq_controller;
  import mac_seq_pkg::*;

  localparam int N        = N_DEF;
  localparam int IDX_W    = IDX_W_DEF;
  localparam int MAX_ITER = MAX_ITER_DEF;
  localparam int ILEN     = N * (N + 2) + 2;

  typedef struct packed {
    logic [4:0]       kind;  // {done, commit, wb, mac, clr}
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic [15:0]      cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst, start, isfinished;
  logic init_w, init_x, clr_acc, mac_en, wb_en, commit, busy, done, timeout;
  logic [IDX_W-1:0] sel_row, sel_col, wb_addr;
  logic [14:0] all_out;

  int n_vec = 0;
  int n_err = 0;
  ev_t q_exp[$];

  always #5 clk = ~clk;

  assign all_out = {init_w, init_x, clr_acc, mac_en, sel_row, sel_col, wb_en, wb_addr,
                    commit, busy, done, timeout};

  mac_seq_controller dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .isfinished (isfinished),
    .init_w     (init_w),
    .init_x     (init_x),
    .clr_acc    (clr_acc),
    .mac_en     (mac_en),
    .sel_row    (sel_row),
    .sel_col    (sel_col),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .commit     (commit),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout)
  );

  function automatic ev_t mk(input int bit_idx, input int row, input int col, input int cyc);
    ev_t e;
    e.kind = 5'(1 << bit_idx);
    e.row  = IDX_W'(row);
    e.col  = IDX_W'(col);
    e.cyc  = 16'(cyc);
    return e;
  endfunction

  // conv = iteration whose CHECK sees isfinished (0: never, run to the cap).
  task automatic run(input int hold, input int conv, input bit noise, input bit restart);
    int  k;
    bit  exp_to, got_done, stray;
    int  limit;
    ev_t obs, exp;
    k      = (conv == 0) ? MAX_ITER : conv;
    exp_to = (conv == 0);
    q_exp.delete();
    for (int it = 0; it < k; it++) begin
      for (int r = 0; r < N; r++) begin
        q_exp.push_back(mk(0, 0, 0, it * ILEN + r * (N + 2)));
        for (int c = 0; c < N; c++) q_exp.push_back(mk(1, r, c, it * ILEN + r * (N + 2) + 1 + c));
        q_exp.push_back(mk(2, r, 0, it * ILEN + r * (N + 2) + N + 1));
      end
      q_exp.push_back(mk(3, 0, 0, it * ILEN + N * (N + 2)));
    end
    q_exp.push_back(mk(4, 0, 0, k * ILEN));

    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_vec++;
      if ({init_w, init_x, busy, timeout} !== 4'b1110) begin
        n_err++;
        $display("FAIL init_phase: got {init_w,init_x,busy,timeout}=%b, required 1110",
                 {init_w, init_x, busy, timeout});
      end
    end
    start = 1'b0;

    got_done = 1'b0;
    stray    = 1'b0;
    limit    = k * ILEN + 4;
    for (int cyc = 0; cyc < limit && !got_done; cyc++) begin
      @(negedge clk);
      obs.kind = {done, commit, wb_en, mac_en, clr_acc};
      obs.row  = mac_en ? sel_row : (wb_en ? wb_addr : '0);
      obs.col  = mac_en ? sel_col : '0;
      obs.cyc  = 16'(cyc);
      if (!busy || init_w || init_x) stray = 1'b1;
      if (obs.kind != 5'b0) begin
        n_vec++;
        if (q_exp.size() == 0) begin
          n_err++;
          $display("FAIL extra_event: got kind=%b at cycle %0d, required no event", obs.kind, cyc);
        end else begin
          exp = q_exp.pop_front();
          if (obs !== exp) begin
            n_err++;
            $display("FAIL event: got kind=%b row=%0d col=%0d cyc=%0d, required kind=%b row=%0d col=%0d cyc=%0d",
                     obs.kind, obs.row, obs.col, obs.cyc, exp.kind, exp.row, exp.col, exp.cyc);
          end
        end
        if (done) begin
          got_done = 1'b1;
          n_vec++;
          if (timeout !== exp_to) begin
            n_err++;
            $display("FAIL timeout_at_done: got %b, required %b", timeout, exp_to);
          end
        end
      end
      if (conv != 0 && cyc == conv * ILEN - 1) isfinished = 1'b1;
      else if (noise && (cyc % ILEN) != ILEN - 1) isfinished = 1'($urandom_range(0, 1));
      else isfinished = 1'b0;
      if (restart && cyc == 3) start = 1'b1;
    end
    isfinished = 1'b0;

    n_vec++;
    if (!got_done) begin
      n_err++;
      $display("FAIL done_wait: got no done within %0d cycles, required done at %0d", limit, k * ILEN);
    end
    n_vec++;
    if (stray) begin
      n_err++;
      $display("FAIL busy_or_init_during_run: got stray busy=0 or init high, required none");
    end
    @(negedge clk);
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL after_done: got {busy,done}=%b, required 00", {busy, done});
    end
    if (restart) begin
      @(negedge clk);
      n_vec++;
      if ({init_w, busy, timeout} !== 3'b110) begin
        n_err++;
        $display("FAIL restart_init: got {init_w,busy,timeout}=%b, required 110",
                 {init_w, busy, timeout});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    isfinished = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (all_out !== 15'b0) begin
        n_err++;
        $display("FAIL reset_idle: got outputs=%b, required all zero", all_out);
      end
    end
  endtask

  task automatic test_single();
    run(3, 1, 1'b0, 1'b0);
  endtask

  task automatic test_conv_third();
    run(2, 3, 1'b1, 1'b0);
  endtask

  task automatic test_cap();
    run(1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({timeout, busy} !== 2'b10) begin
        n_err++;
        $display("FAIL timeout_sticky: got {timeout,busy}=%b, required 10", {timeout, busy});
      end
    end
  endtask

  task automatic test_back_to_back();
    run(2, 1, 1'b0, 1'b1);
    run(2, 2, 1'b0, 1'b0);
  endtask

  task automatic test_cap_and_conv();
    run(2, MAX_ITER, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit found, saw_done;
    @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 4 * ILEN && !found; i++) begin
      @(negedge clk);
      if (mac_en && sel_row == IDX_W'(2)) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL reach_row2: got no mac_en on row 2, required one");
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (all_out !== 15'b0) begin
      n_err++;
      $display("FAIL abort_async: got outputs=%b, required all zero", all_out);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || all_out !== 15'b0) saw_done = 1'b1;
    end
    n_vec++;
    if (saw_done) begin
      n_err++;
      $display("FAIL abort_quiet: got activity or done after abort, required idle zeros");
    end
    run(2, 1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_conv_third();
    test_cap();
    test_back_to_back();
    test_cap_and_conv();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
